// File: rtl/booth_multiplier_seq_32.sv
// ---------------------------------------------------------------------------
// booth_multiplier_seq_32
//
// Sequential signed 32x32 Booth multiplier producing a 64-bit product split
// into HI/LO words. It performs one Booth iteration per clock and uses a
// start/done handshake with the control unit.
//
// Build option:
//   MUL_BIT_PAIR_EN  defined   -> radix-4 bit-pair recoding, 16 iterations
//                    undefined -> radix-2 recoding, 32 iterations
//   The handshake, state set and results are the same in both builds.
//
// Ports:
//   in_clk           system clock, rising edge
//   in_reset         asynchronous active-high reset
//   in_start         start request, accepted whenever out_busy is low
//   in_multiplicand  signed multiplicand M, sampled with in_start
//   in_multiplier    signed multiplier Q, sampled with in_start
//   out_busy         high while iterating (RUN)
//   out_done         one-cycle pulse, product valid from this cycle
//   out_hi           product bits [63:32], held until the next completion
//   out_lo           product bits [31:0], held until the next completion
// ---------------------------------------------------------------------------
module booth_multiplier_seq_32 (
  input  logic        in_clk,
  input  logic        in_reset,
  input  logic        in_start,
  input  logic [31:0] in_multiplicand,
  input  logic [31:0] in_multiplier,
  output logic        out_busy,
  output logic        out_done,
  output logic [31:0] out_hi,
  output logic [31:0] out_lo
);

`ifdef MUL_BIT_PAIR_EN
  // Two guard bits: +/-2M with M = -2^31 needs magnitude 2^32.
  localparam int AW = 34;
  localparam int N  = 16;
`else
  // One guard bit so that -M with M = -2^31 cannot overflow.
  localparam int AW = 33;
  localparam int N  = 32;
`endif

  localparam logic [4:0] CNT_LAST = 5'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [31:0]          m_q, m_d;
  logic [31:0]          q_q, q_d;
  logic                 qm1_q, qm1_d;
  logic signed [AW-1:0] a_q, a_d;
  logic [4:0]           cnt_q, cnt_d;
  logic [31:0]          hi_q, hi_d;
  logic [31:0]          lo_q, lo_d;

  // One Booth step on the current {A, Q, q-1}
  logic signed [AW-1:0] m_ext;
  logic signed [AW-1:0] addend;
  logic signed [AW-1:0] sum;
  logic signed [AW-1:0] a_nxt;
  logic [31:0]          q_nxt;
  logic                 qm1_nxt;

  always_comb begin
    m_ext  = {{(AW-32){m_q[31]}}, m_q};
    addend = '0;
`ifdef MUL_BIT_PAIR_EN
    case ({q_q[1:0], qm1_q})
      3'b001, 3'b010: addend = m_ext;
      3'b011:         addend = m_ext <<< 1;
      3'b100:         addend = -(m_ext <<< 1);
      3'b101, 3'b110: addend = -m_ext;
      default:        addend = '0;
    endcase
    sum     = a_q + addend;
    // Arithmetic shift of {A, Q, q-1} by two bit positions
    a_nxt   = sum >>> 2;
    q_nxt   = {sum[1:0], q_q[31:2]};
    qm1_nxt = q_q[1];
`else
    case ({q_q[0], qm1_q})
      2'b01:   addend = m_ext;
      2'b10:   addend = -m_ext;
      default: addend = '0;
    endcase
    sum     = a_q + addend;
    // Arithmetic shift of {A, Q, q-1} by one bit position
    a_nxt   = sum >>> 1;
    q_nxt   = {sum[0], q_q[31:1]};
    qm1_nxt = q_q[0];
`endif
  end

  // Control and datapath next-state
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    a_d     = a_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (in_start) begin
          state_d = S_RUN;
          m_d     = in_multiplicand;
          q_d     = in_multiplier;
          qm1_d   = 1'b0;
          a_d     = '0;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d   = a_nxt;
        q_d   = q_nxt;
        qm1_d = qm1_nxt;
        cnt_d = cnt_q + 5'd1;
        // The final step's result goes straight to HI/LO so the product is
        // visible in the same cycle that out_done rises.
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          hi_d    = a_nxt[31:0];
          lo_d    = q_nxt;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      a_q     <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign out_busy = (state_q == S_RUN);
  assign out_done = (state_q == S_DONE);
  assign out_hi   = hi_q;
  assign out_lo   = lo_q;

endmodule

// File: tb/tb_booth_multiplier_seq_32.sv
module tb_booth_multiplier_seq_32;

`ifdef MUL_BIT_PAIR_EN
  localparam int N = 16;
`else
  localparam int N = 32;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_bad = 0;

  booth_multiplier_seq_32 dut (
    .in_clk          (clk),
    .in_reset        (rst),
    .in_start        (start),
    .in_multiplicand (mcand),
    .in_multiplier   (mplier),
    .out_busy        (busy),
    .out_done        (done),
    .out_hi          (hi),
    .out_lo          (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start one operation, watch until done (bounded), report timing and product.
  task automatic do_op(input logic [31:0] m, input logic [31:0] q,
                       output int done_at, output int busy_cnt,
                       output logic [63:0] prod);
    done_at  = 0;
    busy_cnt = 0;
    prod     = '0;
    @(negedge clk);
    start  = 1'b1;
    mcand  = m;
    mplier = q;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= N + 10; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done && done_at == 0) begin
        done_at = k;
        prod    = {hi, lo};
      end
      if (done_at != 0) break;
    end
  endtask

  int          d_at, b_cnt, d_cnt, d_at2;
  logic [63:0] prod, prod2;
  logic        lo_moved;

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    mcand  = '0;
    mplier = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    rst = 1'b0;

    // 7 x -3
    do_op(32'd7, 32'hFFFF_FFFD, d_at, b_cnt, prod);
    chk("m7q-3_busy_cycles", 64'(b_cnt), 64'(N));
    chk("m7q-3_done_at", 64'(d_at), 64'(N + 1));
    chk("m7q-3_prod", prod, 64'hFFFF_FFFF_FFFF_FFEB);
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("hilo_hold_idle", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

    // Most negative squared
    do_op(32'h8000_0000, 32'h8000_0000, d_at, b_cnt, prod);
    chk("minneg_sq_done_at", 64'(d_at), 64'(N + 1));
    chk("minneg_sq_prod", prod, 64'h4000_0000_0000_0000);

    // -1 x -1
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, d_at, b_cnt, prod);
    chk("neg1_sq_prod", prod, 64'h0000_0000_0000_0001);

    // 5 x 6, then 3 x 4 with an ignored mid-RUN start
    do_op(32'd5, 32'd6, d_at, b_cnt, prod);
    chk("m5q6_prod", prod, 64'd30);
    @(negedge clk);
    start  = 1'b1;
    mcand  = 32'd3;
    mplier = 32'd4;
    @(posedge clk);
    #1 start = 1'b0;
    d_cnt    = 0;
    lo_moved = 1'b0;
    for (int k = 1; k <= N + 10; k++) begin
      @(negedge clk);
      if (busy && lo != 32'd30) lo_moved = 1'b1;
      if (done) d_cnt++;
      if (k == 5) begin
        start  = 1'b1;
        mcand  = 32'd9;
        mplier = 32'd9;
      end else begin
        start  = 1'b0;
      end
    end
    chk("ignore_lo_held_in_run", 64'(lo_moved), 64'd0);
    chk("ignore_done_count", 64'(d_cnt), 64'd1);
    chk("ignore_prod", {hi, lo}, 64'd12);

    // Asynchronous reset mid-RUN
    @(negedge clk);
    start  = 1'b1;
    mcand  = 32'd11;
    mplier = 32'd13;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst   = 1'b0;
    d_cnt = 0;
    b_cnt = 0;
    for (int k = 1; k <= N + 5; k++) begin
      @(negedge clk);
      if (done) d_cnt++;
      if (busy) b_cnt++;
    end
    chk("arst_no_done", 64'(d_cnt), 64'd0);
    chk("arst_no_busy", 64'(b_cnt), 64'd0);

    // in_start held high: back-to-back 2x3 then 0x7FFFFFFF x 2
    @(negedge clk);
    start  = 1'b1;
    mcand  = 32'd2;
    mplier = 32'd3;
    @(posedge clk);
    d_at  = 0;
    d_at2 = 0;
    prod  = '0;
    prod2 = '0;
    for (int k = 1; k <= 3 * N; k++) begin
      @(negedge clk);
      if (done) begin
        if (d_at == 0) begin
          d_at = k;
          prod = {hi, lo};
        end else if (d_at2 == 0) begin
          d_at2 = k;
          prod2 = {hi, lo};
        end
      end
      if (k == 1) begin
        mcand  = 32'h7FFF_FFFF;
        mplier = 32'd2;
      end
    end
    start = 1'b0;
    chk("b2b_done1_at", 64'(d_at), 64'(N + 1));
    chk("b2b_prod1", prod, 64'd6);
    chk("b2b_done2_at", 64'(d_at2), 64'(2 * N + 2));
    chk("b2b_prod2", prod2, 64'h0000_0000_FFFF_FFFE);

    repeat (N + 4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/booth_multiplier_seq_32.md
# booth_multiplier_seq_32

Sequential signed 32×32 multiplier producing a 64-bit product split into HI and LO words. It is the multiply counterpart to the datapath's combinational array divider and feeds the HI/LO registers for `mul`. It uses Booth recoding with one iteration per clock and a start/done handshake with the control unit. It is sized for a small area footprint in exchange for multi-cycle latency.

## Interface
Parameters:
- none; width fixed at 32 (product 64).

Ports:
- in_clk  input  1  — system clock; all state updates on the rising edge.
- in_reset  input  1  — asynchronous, active-high reset.
- in_start  input  1  — request a multiply. Sampled on a rising edge while out_busy is low.
- in_multiplicand  input  32  — signed two's-complement M. Sampled with in_start.
- in_multiplier  input  32  — signed two's-complement Q. Sampled with in_start.
- out_busy  output  1  — high while iterating (RUN state).
- out_done  output  1  — one-cycle pulse; the product is valid from this cycle.
- out_hi  output  32  — product bits [63:32].
- out_lo  output  32  — product bits [31:0].

## Operation
- States:
  - IDLE: out_busy=0, out_done=0.
  - RUN: out_busy=1.
  - DONE: out_done=1, out_busy=0.
- Transitions:
  - IDLE→RUN on in_start.
  - RUN→DONE when the iteration counter reaches N−1.
  - DONE→RUN if in_start is high, otherwise DONE→IDLE.
- Start latches M, Q, clears the accumulator A and q₋₁, and zeroes the counter.
- Radix-2 iteration, with A at 33 bits sign-extended so that M = −2³¹ cannot overflow:
  - {Q[0], q₋₁}=01: A += M.
  - {Q[0], q₋₁}=10: A −= M.
  - 00/11: A unchanged.
  - Then arithmetic shift right of {A, Q, q₋₁} by 1.
- After N=32 iterations the product is {A[31:0], Q}. It is loaded into out_hi/out_lo on the RUN→DONE edge.
- out_hi/out_lo hold the last completed product until the next completion. They do not change during RUN.
- in_start while out_busy=1 is ignored. Operand changes during RUN have no effect.
- All arithmetic is mod 2⁶⁴ two's complement. The 64-bit signed product is always exact; no overflow flag.

## Timing
- Reset (asynchronous, any state): state=IDLE, out_busy=0, out_done=0, out_hi=0, out_lo=0, internal registers cleared. An in-flight operation is discarded.
- Start sampled at edge E0. out_busy is high for the N cycles following E0. out_done is high for exactly one cycle beginning at edge E0+N. out_hi/out_lo are valid from E0+N.
- Latency: N+1 edges from start to out_done deassertion. Throughput is one product per N+1 cycles, or back-to-back when the next start arrives in the DONE cycle.
- in_start held high continuously: a new operation starts in every DONE cycle.

## Configuration
- `MUL_BIT_PAIR_EN` defined:
  - Radix-4 bit-pair recoding. Each iteration examines {Q[1:0], q₋₁} and adds 0, ±M or ±2M to a 34-bit sign-extended A, then shifts right arithmetically by 2.
  - N=16: out_done at E0+16, out_busy high 16 cycles.
- Undefined: radix-2 as above, N=32.
- The handshake, state set and results are identical in both builds; only N differs.

## Test plan
- M=7, Q=−3 (0xFFFFFFFD), start at E0 → out_busy high N cycles; at E0+N out_done=1, out_hi=0xFFFFFFFF, out_lo=0xFFFFFFEB.
- M=0x80000000, Q=0x80000000 → out_hi=0x40000000, out_lo=0x00000000. Separately, M=−1, Q=−1 → out_hi=0, out_lo=1.
- Complete 5×6 (out_lo=30); then start 3×4 and pulse in_start with different operands mid-RUN → the second pulse is ignored. out_lo holds 30 during RUN and becomes 12 at completion; exactly one out_done.
- Assert in_reset mid-RUN, asynchronously off-edge → all outputs 0 immediately. After release, no out_done without a fresh start.
- in_start held high across two operations, 2×3 then 0x7FFFFFFF×2 → out_done pulses at E0+N and E0+2N+1. The second result is out_hi=0, out_lo=0xFFFFFFFE.
- Rerun the above with `MUL_BIT_PAIR_EN` defined → identical products, N=16.
